// File: rtl/spn_pkg.sv
// Shared types and constants for the SPN request master.
// Op, core-valid and response-status encodings, the FSM state enum, and an op helper.
package spn_pkg;

  localparam int DATA_W = 16;
  localparam int KEY_W  = 32;
  localparam int OP_W   = 2;

  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_ENC = 2'b01,
    OP_DEC = 2'b10,
    OP_UND = 2'b11
  } spn_op_e;

  typedef enum logic [1:0] {
    VLD_NONE = 2'b00,
    VLD_ENC  = 2'b01,
    VLD_DEC  = 2'b10,
    VLD_ERR  = 2'b11
  } spn_valid_e;

  typedef enum logic [1:0] {
    ST_OK       = 2'b00,
    ST_CORE_ERR = 2'b01,
    ST_TIMEOUT  = 2'b10,
    ST_ILLEGAL  = 2'b11
  } spn_status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_RESP  = 2'b11
  } spn_req_state_e;

  function automatic logic op_is_legal(input logic [OP_W-1:0] op);
    return (op == OP_ENC) || (op == OP_DEC);
  endfunction

  // Completion code the core must report for a given op.
  function automatic logic [1:0] valid_for_op(input logic [OP_W-1:0] op);
    logic [1:0] v;
    case (op)
      OP_ENC:  v = VLD_ENC;
      OP_DEC:  v = VLD_DEC;
      default: v = VLD_ERR;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/spn_wait_timer.sv
// Saturating wait counter; expired is high on the TIMEOUT_CYCLES-th enabled cycle.
module spn_wait_timer #(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOP  = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (enable && (cnt_q != TOP)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/spn_req_master.sv
// Request-side master for the SPN core: one job in, one status-tagged response out.
// Optional feature: define SPN_ERR_CNT_EN to add a saturating err_count[7:0] output.
module spn_req_master
  import spn_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 8,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [OP_W-1:0]   req_op,
  input  logic [DATA_W-1:0] req_data,
  input  logic [KEY_W-1:0]  req_key,
  output logic [OP_W-1:0]   spn_opcode,
  output logic [DATA_W-1:0] spn_in_data,
  output logic [KEY_W-1:0]  spn_key,
  input  logic [DATA_W-1:0] spn_out_data,
  input  logic [1:0]        spn_valid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  output logic              busy
`ifdef SPN_ERR_CNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  spn_req_state_e    state_q, state_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [OP_W-1:0]   spn_opcode_q, spn_opcode_d;
  logic [DATA_W-1:0] spn_in_data_q, spn_in_data_d;
  logic [KEY_W-1:0]  spn_key_q, spn_key_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]        rsp_status_q, rsp_status_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              tmr_clear, tmr_enable, tmr_expired;

  spn_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_expired)
  );

  // Next-state and next-output logic; a core completion beats a same-cycle expiry.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    spn_opcode_d  = OP_NOP;
    spn_in_data_d = spn_in_data_q;
    spn_key_d     = spn_key_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_data_d    = rsp_data_q;
    rsp_status_d  = rsp_status_q;
    tmr_clear     = 1'b1;
    tmr_enable    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d = req_op;
          if (op_is_legal(req_op)) begin
            spn_opcode_d  = req_op;
            spn_in_data_d = req_data;
            spn_key_d     = req_key;
            state_d       = S_ISSUE;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_data_d   = {DATA_W{1'b0}};
            rsp_status_d = ST_ILLEGAL;
            state_d      = S_RESP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        tmr_clear  = 1'b0;
        tmr_enable = 1'b1;
        if (spn_valid != VLD_NONE) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          spn_in_data_d = {DATA_W{1'b0}};
          spn_key_d     = {KEY_W{1'b0}};
          if (spn_valid == valid_for_op(op_q)) begin
            rsp_data_d   = spn_out_data;
            rsp_status_d = ST_OK;
          end else begin
            rsp_data_d   = {DATA_W{1'b0}};
            rsp_status_d = ST_CORE_ERR;
          end
        end else if (tmr_expired) begin
          state_d       = S_RESP;
          rsp_valid_d   = 1'b1;
          spn_in_data_d = {DATA_W{1'b0}};
          spn_key_d     = {KEY_W{1'b0}};
          rsp_data_d    = {DATA_W{1'b0}};
          rsp_status_d  = ST_TIMEOUT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          rsp_data_d   = {DATA_W{1'b0}};
          rsp_status_d = ST_OK;
          state_d      = S_IDLE;
        end else begin
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    req_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  // State and registered outputs; reset drops any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NOP;
      spn_opcode_q  <= OP_NOP;
      spn_in_data_q <= {DATA_W{1'b0}};
      spn_key_q     <= {KEY_W{1'b0}};
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= {DATA_W{1'b0}};
      rsp_status_q  <= ST_OK;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      spn_opcode_q  <= spn_opcode_d;
      spn_in_data_q <= spn_in_data_d;
      spn_key_q     <= spn_key_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_status_q  <= rsp_status_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign spn_opcode  = spn_opcode_q;
  assign spn_in_data = spn_in_data_q;
  assign spn_key     = spn_key_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_status  = rsp_status_q;
  assign busy        = busy_q;

`ifdef SPN_ERR_CNT_EN
  logic [7:0] err_count_q, err_count_d;

  // Count each non-OK response once, on the cycle it is created.
  always_comb begin
    err_count_d = err_count_q;
    if ((state_q != S_RESP) && (state_d == S_RESP) &&
        (rsp_status_d != ST_OK) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_q <= 8'h00;
    end else begin
      err_count_q <= err_count_d;
    end
  end

  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_spn_req_master.sv
// Scoreboard bench for spn_req_master with a stub SPN core (TIMEOUT_CYCLES = 8).
module tb_spn_req_master;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [15:0] req_data;
  logic [31:0] req_key;
  logic [1:0]  spn_opcode;
  logic [15:0] spn_in_data;
  logic [31:0] spn_key;
  logic [15:0] spn_out_data;
  logic [1:0]  spn_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_status;
  logic        busy;
`ifdef SPN_ERR_CNT_EN
  logic [7:0]  err_count;
`endif

  spn_req_master #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_data    (req_data),
    .req_key     (req_key),
    .spn_opcode  (spn_opcode),
    .spn_in_data (spn_in_data),
    .spn_key     (spn_key),
    .spn_out_data(spn_out_data),
    .spn_valid   (spn_valid),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_status  (rsp_status),
    .busy        (busy)
`ifdef SPN_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  st;
    logic [15:0] d;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass;
  int   n_total;
  int   n_err_exp;

  logic [1:0]  stub_code;
  int          stub_delay;
  logic [15:0] stub_out;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total = n_total + 1;
    if (act === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Stub core: answers a legal issue after stub_delay clocks with a one-cycle code.
  initial begin
    spn_valid    = 2'b00;
    spn_out_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (spn_opcode != 2'b00 && stub_code != 2'b00) begin
        repeat (stub_delay) @(posedge clk);
        #1;
        spn_valid    = stub_code;
        spn_out_data = stub_out;
        @(posedge clk);
        #1;
        spn_valid    = 2'b00;
        spn_out_data = 16'h0000;
      end
    end
  end

  // Monitor: pops and compares on every response handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_total = n_total + 1;
          $display("FAIL unexpected_rsp: got status %0h data %0h, none expected", rsp_status, rsp_data);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_status", 64'(rsp_status), 64'(e.st));
          chk("rsp_data", 64'(rsp_data), 64'(e.d));
        end
      end
    end
  end

  task automatic offer(input logic [1:0] op, input logic [15:0] data, input logic [31:0] key,
                       input string nm);
    bit got;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    req_key   = key;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      got = req_ready;
    end
    chk({nm, " accept"}, 64'(got), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_data  = 16'h0000;
    req_key   = 32'h0000_0000;
  endtask

  task automatic run_job(input logic [1:0] op, input logic [15:0] data, input logic [31:0] key,
                         input logic [1:0] s_code, input int s_delay, input logic [15:0] s_out,
                         input logic [1:0] e_st, input logic [15:0] e_data, input int e_lat,
                         input int hold, input string nm);
    exp_t        e;
    int          n;
    int          opc;
    bit          got;
    bit          stable;
    bit          legal;
    logic [15:0] hd;
    logic [1:0]  hs;
    legal      = (op == 2'b01) || (op == 2'b10);
    stub_code  = s_code;
    stub_delay = s_delay;
    stub_out   = s_out;
    e.st = e_st;
    e.d  = e_data;
    exp_q.push_back(e);
    if (e_st != 2'b00) n_err_exp = n_err_exp + 1;
    rsp_ready = (hold == 0);
    offer(op, data, key, nm);
    n = 0; opc = 0; got = 1'b0;
    while (!got && n < 40) begin
      @(negedge clk);
      n = n + 1;
      if (spn_opcode != 2'b00) begin
        opc = opc + 1;
        if (opc == 1) begin
          chk({nm, " opcode"}, 64'(spn_opcode), 64'(op));
          chk({nm, " in_data"}, 64'(spn_in_data), 64'(data));
          chk({nm, " key"}, 64'(spn_key), 64'(key));
        end
      end
      got = rsp_valid;
    end
    chk({nm, " latency"}, 64'(n), 64'(e_lat));
    chk({nm, " opcode_cycles"}, 64'(opc), legal ? 64'd1 : 64'd0);
    chk({nm, " pins_cleared"}, {14'd0, spn_opcode, spn_in_data, spn_key}, 64'd0);
    if (hold > 0) begin
      hd = rsp_data;
      hs = rsp_status;
      stable = 1'b1;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!rsp_valid || rsp_data != hd || rsp_status != hs || req_ready || !busy) stable = 1'b0;
      end
      chk({nm, " held_stable"}, 64'(stable), 64'd1);
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({nm, " rsp_dropped"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    n_pass = 0; n_total = 0; n_err_exp = 0;
    stub_code = 2'b00; stub_delay = 0; stub_out = 16'h0000;
    reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = 16'h0000;
    req_key = 32'h0000_0000; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {41'd0, req_ready, busy, rsp_valid, rsp_status, rsp_data, spn_opcode}, 64'd0);
    chk("reset_pins", {16'd0, spn_in_data, spn_key}, 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run_job(2'b01, 16'h1234, 32'hA5A5_0F0F, 2'b01, 3, 16'hBEEF, 2'b00, 16'hBEEF, 5, 0, "enc");
    run_job(2'b10, 16'h5555, 32'h0123_4567, 2'b01, 2, 16'hCAFE, 2'b01, 16'h0000, 4, 0, "dec_wrong");
    run_job(2'b10, 16'h0F0F, 32'hDEAD_BEEF, 2'b11, 1, 16'h7777, 2'b01, 16'h0000, 3, 0, "dec_err");
    run_job(2'b01, 16'hAAAA, 32'h1111_2222, 2'b00, 0, 16'h0000, 2'b10, 16'h0000, 10, 0, "timeout");
    run_job(2'b10, 16'h3C3C, 32'h89AB_CDEF, 2'b10, 8, 16'h4242, 2'b00, 16'h4242, 10, 0, "late_ok");
    run_job(2'b11, 16'h1111, 32'h2222_3333, 2'b00, 0, 16'h0000, 2'b11, 16'h0000, 1, 0, "illegal_und");
    run_job(2'b00, 16'h4444, 32'h5555_6666, 2'b00, 0, 16'h0000, 2'b11, 16'h0000, 1, 0, "illegal_nop");
    run_job(2'b01, 16'h0001, 32'hFFFF_FFFF, 2'b01, 5, 16'h9999, 2'b00, 16'h9999, 7, 10, "backpressure");
`ifdef SPN_ERR_CNT_EN
    chk("err_count", 64'(err_count), 64'(n_err_exp));
`endif

    // Abort a job in WAIT with reset; no response may follow.
    stub_code = 2'b00;
    rsp_ready = 1'b1;
    offer(2'b01, 16'h7E7E, 32'hCCCC_DDDD, "abort");
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_ctrl", {41'd0, req_ready, busy, rsp_valid, rsp_status, rsp_data, spn_opcode}, 64'd0);
    chk("abort_pins", {16'd0, spn_in_data, spn_key}, 64'd0);
`ifdef SPN_ERR_CNT_EN
    chk("abort_err_count", 64'(err_count), 64'd0);
`endif
    @(posedge clk);
    #1 reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid || busy) seen = 1'b1;
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);

    run_job(2'b01, 16'h2468, 32'h1357_9BDF, 2'b01, 1, 16'hF00D, 2'b00, 16'hF00D, 3, 0, "post_reset");

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
